// File: rtl/vx_mp_ram_clr_if.sv
// Bus bundle for vx_mp_ram_clr: clear/ready handshake, one write port and
// NUM_RPORTS packed read ports.
interface vx_mp_ram_clr_if #(
    parameter int unsigned DATAW      = 32,
    parameter int unsigned NUM_RPORTS = 2,
    parameter int unsigned WRENW      = 4,
    parameter int unsigned ADDRW      = 6
);
    logic                        clear;
    logic                        ready;
    logic                        write;
    logic [WRENW-1:0]            wren;
    logic [ADDRW-1:0]            waddr;
    logic [DATAW-1:0]            wdata;
    logic [NUM_RPORTS-1:0]       read;
    logic [NUM_RPORTS*ADDRW-1:0] raddr;
    logic [NUM_RPORTS*DATAW-1:0] rdata;

    modport master (
        output clear, write, wren, waddr, wdata, read, raddr,
        input  ready, rdata
    );

    modport slave (
        input  clear, write, wren, waddr, wdata, read, raddr,
        output ready, rdata
    );
endinterface

// File: rtl/vx_mp_ram_clr.sv
// Multi-read-port RAM that re-initialises itself word by word after reset or clear.
// Define VX_MP_RAM_FWD_EN to forward same-cycle write data to reads of waddr.
module vx_mp_ram_clr #(
    parameter int unsigned      DATAW      = 32,
    parameter int unsigned      SIZE       = 64,
    parameter int unsigned      NUM_RPORTS = 2,
    parameter int unsigned      WRENW      = 4,
    parameter int unsigned      OUT_REG    = 0,
    parameter logic [DATAW-1:0] INIT_VALUE = '0,
    parameter int unsigned      ADDRW      = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input logic            clk,
    input logic            reset,
    vx_mp_ram_clr_if.slave bus
);
    localparam int unsigned LANEW = DATAW / WRENW;

    if ((DATAW % WRENW) != 0) begin : g_bad_wrenw
        $error("DATAW must be a multiple of WRENW");
    end

    typedef enum logic {StClear, StReady} state_e;

    state_e           state_q, state_d;
    logic [ADDRW-1:0] cnt_q, cnt_d;
    logic [DATAW-1:0] ram_q [SIZE];
    logic [DATAW-1:0] rd_word [NUM_RPORTS];
    logic [DATAW-1:0] wmask;
    logic             ready;
    logic             wr_accept;

    assign ready     = (state_q == StReady);
    assign bus.ready = ready;
    assign wr_accept = ready && bus.write && !bus.clear;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StClear: begin
                cnt_d = cnt_q + ADDRW'(1);
                if (bus.clear) begin
                    cnt_d = '0;
                end else if (cnt_q == ADDRW'(SIZE - 1)) begin
                    state_d = StReady;
                    cnt_d   = '0;
                end
            end
            StReady: begin
                if (bus.clear) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StClear;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        wmask = '0;
        for (int i = 0; i < WRENW; i++) begin
            wmask[i*LANEW +: LANEW] = {LANEW{bus.wren[i]}};
        end
    end

    // No reset on the array itself; the CLEAR sweep initialises it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == StClear) begin
                ram_q[cnt_q] <= INIT_VALUE;
            end else if (wr_accept) begin
                ram_q[bus.waddr] <= (ram_q[bus.waddr] & ~wmask) | (bus.wdata & wmask);
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_RPORTS; p++) begin
            rd_word[p] = ram_q[bus.raddr[p*ADDRW +: ADDRW]];
`ifdef VX_MP_RAM_FWD_EN
            if (wr_accept && (bus.raddr[p*ADDRW +: ADDRW] == bus.waddr)) begin
                rd_word[p] = (rd_word[p] & ~wmask) | (bus.wdata & wmask);
            end
`endif
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATAW-1:0] rdata_q [NUM_RPORTS];

        always_ff @(posedge clk) begin
            for (int p = 0; p < NUM_RPORTS; p++) begin
                if (reset) begin
                    rdata_q[p] <= '0;
                end else if (bus.read[p] && ready) begin
                    rdata_q[p] <= rd_word[p];
                end
            end
        end

        always_comb begin
            bus.rdata = '0;
            for (int p = 0; p < NUM_RPORTS; p++) begin
                bus.rdata[p*DATAW +: DATAW] = rdata_q[p];
            end
        end
    end else begin : g_out_comb
        logic unused_read;
        assign unused_read = ^bus.read;

        always_comb begin
            bus.rdata = '0;
            for (int p = 0; p < NUM_RPORTS; p++) begin
                bus.rdata[p*DATAW +: DATAW] = ready ? rd_word[p] : INIT_VALUE;
            end
        end
    end
endmodule

// File: doc/vx_mp_ram_clr.md
VX_MP_RAM_CLR -- requirements
Module: VX_mp_ram_clr

Interface
REQ-001 SHALL have parameter DATAW, default 32, word width in bits.
REQ-002 SHALL have parameter SIZE, default 64, number of words (>=2).
REQ-003 SHALL have parameter NUM_RPORTS, default 2, number of independent read ports (>=1).
REQ-004 SHALL have parameter WRENW, default 4, write-enable lanes; DATAW SHALL be a multiple of WRENW (static assert).
REQ-005 SHALL have parameter OUT_REG, default 0, 0 = combinational read, 1 = registered read.
REQ-006 SHALL have parameter INIT_VALUE [DATAW-1:0], default 0, value written to every word on clear.
REQ-007 SHALL have parameter ADDRW, default LOG2UP(SIZE), address width.
REQ-008 SHALL have port clk input 1, sole clock; reset is synchronous and active-high.
REQ-009 SHALL have port reset input 1, synchronous active-high reset.
REQ-010 SHALL have port clear input 1, run-time request to re-initialise the array.
REQ-011 SHALL have port ready output 1, high when the array is initialised and accepting accesses.
REQ-012 SHALL have port write input 1, write strobe.
REQ-013 SHALL have port wren input WRENW, per-lane write enables, lane width DATAW/WRENW.
REQ-014 SHALL have port waddr input ADDRW, write address.
REQ-015 SHALL have port wdata input DATAW, write data.
REQ-016 SHALL have port read input NUM_RPORTS, per-port read strobe.
REQ-017 SHALL have port raddr input NUM_RPORTS*ADDRW, packed read addresses, port p at [p*ADDRW +: ADDRW].
REQ-018 SHALL have port rdata output NUM_RPORTS*DATAW, packed read data, port p at [p*DATAW +: DATAW].

Function
REQ-019 SHALL implement a two-state FSM, CLEAR and READY; ready = (state == READY).
REQ-020 In CLEAR, each cycle SHALL write INIT_VALUE to word cnt and increment cnt; after writing word SIZE-1, it SHALL enter READY on the next edge.
REQ-021 ready SHALL rise exactly SIZE clock edges after the first edge with reset low.
REQ-022 In READY, clear=1 SHALL enter CLEAR with cnt=0; in CLEAR, clear=1 SHALL restart cnt at 0.
REQ-023 In READY, write=1 and clear=0 SHALL update ram[waddr] lanes where wren[i]=1; all other lanes are unchanged.
REQ-024 Writes SHALL be dropped when ready=0 or clear=1 (clear wins over a simultaneous write).
REQ-025 OUT_REG=0: rdata port p = ram[raddr_p] combinationally, forced to INIT_VALUE while ready=0; read is ignored.
REQ-026 OUT_REG=1: rdata_r[p] <= ram[raddr_p] on edges with read[p]=1 and ready=1; otherwise it holds; latency 1 cycle.
REQ-027 Read ports SHALL be fully independent; identical addresses on several ports SHALL return identical data.

Reset
REQ-028 reset SHALL force state=CLEAR, cnt=0, ready=0, and all registered rdata=0; array contents are then cleared by the FSM, not in one cycle.
REQ-029 reset asserted mid-clear or mid-write SHALL take priority over all other inputs on that edge.

Configuration
REQ-030 Macro VX_MP_RAM_FWD_EN defined: a read of waddr in the same cycle as an accepted write SHALL return the new data per lane (wdata where wren[i], else stored data), for both OUT_REG values.
REQ-031 Macro VX_MP_RAM_FWD_EN undefined: the same-cycle read SHALL return the pre-write contents; no bypass logic SHALL be present.

Verification
REQ-032 SIZE=64: deassert reset -> ready=0 for 63 edges, ready=1 after edge 64; every address reads INIT_VALUE.
REQ-033 READY, write waddr=5 wdata=0xAABBCCDD wren=0b0101 over 0 -> next read of 5 = 0x00BB00DD on all ports.
REQ-034 Write of addr 7 with clear=1 in the same cycle -> write dropped, ready=0 for 64 cycles, addr 7 reads INIT_VALUE.
REQ-035 FWD_EN, OUT_REG=1, write addr 3 = 0x12345678 with read of addr 3 in the same cycle -> rdata=0x12345678 next cycle; without FWD_EN -> old value.
REQ-036 reset pulsed at cnt=30 -> cnt restarts at 0; ready rises 64 edges after reset deasserts; rdata registers read 0.
